dcache_flush_unit: RTL
======================

// Module: dcache_flush_unit
// PURPOSE
// Dcache-side responder to the pipeline flush controller's flush/stall/init signals.
// - On flush_i: walks every set, writes back valid+dirty ways through the writeback port, invalidates each set, then pulses flush_ack_o.
// - After reset with init_ni low: invalidates the whole tag array before serving requests.
// - Reports cache busy so the controller can drain before a micro-architectural reset.
// PARAMETERS
// NUM_SETS  256  sets in tag array, power of 2; IDX_W = $clog2(NUM_SETS)
// NUM_WAYS  8    ways per set, power of 2; WAY_W = $clog2(NUM_WAYS)
// TAG_W     44   tag bits per way
// OFFSET_W  4    line offset bits; writeback address width PLEN = TAG_W+IDX_W+OFFSET_W
// PORTS
// clk_i        in   1                 clock
// rst_ni       in   1                 asynchronous active-low reset
// flush_i      in   1                 flush request, level, held by requester until ack
// flush_ack_o  out  1                 one-cycle pulse: flush complete
// stall_i      in   1                 do not accept new core requests
// init_ni      in   1                 low: run tag init after reset; high: skip init
// miss_busy_i  in   1                 miss/refill unit has outstanding bus transactions
// busy_o       out  1                 cache busy (to controller drain counter)
// gate_core_o  out  1                 cache front-end must not accept core requests
// tag_req_o    out  1                 tag array access request
// tag_we_o     out  1                 1: write valid=0,dirty=0 to all ways of tag_idx_o; 0: read
// tag_idx_o    out  IDX_W             set index
// tag_gnt_i    in   1                 tag array grant
// tag_rvld_i   in   NUM_WAYS          valid bits, one cycle after read grant
// tag_rdirty_i in   NUM_WAYS          dirty bits, one cycle after read grant
// tag_rtag_i   in   NUM_WAYS*TAG_W    tags, way w at [w*TAG_W +: TAG_W], one cycle after read grant
// wb_valid_o   out  1                 writeback request valid
// wb_ready_i   in   1                 writeback request accepted
// wb_addr_o    out  PLEN              {tag, idx, OFFSET_W'0}
// wb_way_o     out  WAY_W             way to write back
// BEHAVIOUR
// Reset: every output 0; idx/way counters 0. First state after reset: INIT if init_ni==0 at the first clock after reset release, else IDLE.
// States: INIT, IDLE, RD, CHK, WB, INV, ACK, COOL.
// INIT: tag_req_o=1, tag_we_o=1, tag_idx_o=idx; on tag_gnt_i: idx++; after the grant at idx==NUM_SETS-1: idx=0, go IDLE.
// IDLE: on flush_i: idx=0, go RD. A flush_i raised during INIT waits until INIT completes.
// RD: tag read of idx; on tag_gnt_i go CHK. Next cycle, capture rvld/rdirty/rtag into registers.
// CHK: pend = rvld & rdirty. If pend==0 go INV, else way = lowest set bit of pend, go WB.
// WB: wb_valid_o=1 with addr/way stable until wb_ready_i. On wb_ready_i clear pend[way].
//     If the remaining pend != 0, next lowest way, stay WB; else go INV. Ways go out in ascending order, one per handshake.
// INV: tag write of idx. On tag_gnt_i: if idx==NUM_SETS-1 go ACK, else idx++ and go RD.
// ACK: flush_ack_o=1 for exactly one cycle; go COOL.
// COOL: ignore flush_i for one cycle (requester deasserts flush_i one cycle after ack); go IDLE.
// tag_req_o, tag_we_o and tag_idx_o stay stable while tag_gnt_i is low.
// gate_core_o = stall_i | (state != IDLE). Combinational, no added latency.
// busy_o = (state != IDLE) | miss_busy_i | wb_valid_o.
// Counters wrap only via explicit reset to 0 at NUM_SETS-1. There is no overflow path.
// Reset asserted mid-walk: walk aborts immediately, no ack, pending writebacks dropped. INIT re-runs if init_ni is low.
// Minimum flush latency with no dirty lines and grants always high: 3*NUM_SETS cycles from flush_i to flush_ack_o (RD, CHK, INV per set).
// TESTING
// init_ni=0, release reset, tag_gnt_i=1 -> 256 tag writes idx 0..255, then IDLE; busy_o=1 for exactly 256 cycles.
// init_ni=1, release reset -> no tag_req_o; IDLE on the first cycle; flush_i pulse -> flush_ack_o after 768 cycles.
// set 5, ways 2 and 6 valid+dirty, tags 0xA and 0xB -> wb way 2 addr {0xA,8'd5,4'd0} then way 6; set 5 invalidated; ack.
// wb_ready_i held low for 10 cycles during WB -> wb_valid_o/addr/way stable; tag_gnt_i low 3 cycles -> request stable.
// flush_i held high 1 cycle after ack -> no second walk; flush_i re-raised 3 cycles later -> new walk starts.
// reset asserted in WB at set 100 -> all outputs 0 immediately; no ack; after release IDLE (init_ni=1); stall_i=1 -> gate_core_o=1.

Source files
------------

// File: rtl/dcache_flush_unit.sv
`default_nettype none
// ============================================================================
// Module      : dcache_flush_unit
// Description : Dcache-side responder to the pipeline flush controller.
//               Initialises the tag array after reset, walks every set on a
//               flush request writing back valid+dirty ways and invalidating
//               each set, then pulses flush_ack_o. Reports busy / front-end
//               gating to the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_flush_unit #(
  parameter int NUM_SETS = 256,
  parameter int NUM_WAYS = 8,
  parameter int TAG_W    = 44,
  parameter int OFFSET_W = 4,
  localparam int IDX_W   = $clog2(NUM_SETS),
  localparam int WAY_W   = $clog2(NUM_WAYS),
  localparam int PLEN    = TAG_W + IDX_W + OFFSET_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  output logic                      flush_ack_o,
  input  logic                      stall_i,
  input  logic                      init_ni,
  input  logic                      miss_busy_i,
  output logic                      busy_o,
  output logic                      gate_core_o,
  output logic                      tag_req_o,
  output logic                      tag_we_o,
  output logic [IDX_W-1:0]          tag_idx_o,
  input  logic                      tag_gnt_i,
  input  logic [NUM_WAYS-1:0]       tag_rvld_i,
  input  logic [NUM_WAYS-1:0]       tag_rdirty_i,
  input  logic [NUM_WAYS*TAG_W-1:0] tag_rtag_i,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [PLEN-1:0]           wb_addr_o,
  output logic [WAY_W-1:0]          wb_way_o
);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_INV  = 3'd5;
  localparam logic [2:0] S_ACK  = 3'd6;
  localparam logic [2:0] S_COOL = 3'd7;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SETS - 1);

  logic [2:0]                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [WAY_W-1:0]          way_q, way_d;
  logic [NUM_WAYS-1:0]       pend_q, pend_d;
  logic [NUM_WAYS*TAG_W-1:0] tags_q, tags_d;
  // Set only for the first clock after reset release, where init_ni decides
  // whether the tag array gets cleared.
  logic                      start_q, start_d;

  logic [NUM_WAYS-1:0]       pend_new;
  logic [NUM_WAYS-1:0]       pend_rem;

  // Priority pick of the lowest set bit: ways are written back in ascending order.
  function automatic logic [WAY_W-1:0] lowest_way(input logic [NUM_WAYS-1:0] v);
    lowest_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (v[w]) lowest_way = WAY_W'(w);
    end
  endfunction

  // Next-state and datapath update for the init / flush walk.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    way_d    = way_q;
    pend_d   = pend_q;
    tags_d   = tags_q;
    start_d  = 1'b0;
    pend_new = tag_rvld_i & tag_rdirty_i;
    pend_rem = pend_q & ~(NUM_WAYS'(1) << way_q);
    case (state_q)
      S_IDLE: begin
        if (start_q && !init_ni) begin
          idx_d   = '0;
          state_d = S_INIT;
        end else if (flush_i) begin
          idx_d   = '0;
          state_d = S_RD;
        end
      end
      S_INIT: begin
        if (tag_gnt_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_RD: begin
        if (tag_gnt_i) state_d = S_CHK;
      end
      S_CHK: begin
        // Read data arrives in this cycle; capture it for the writeback phase.
        tags_d = tag_rtag_i;
        pend_d = pend_new;
        if (pend_new == '0) begin
          state_d = S_INV;
        end else begin
          way_d   = lowest_way(pend_new);
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (wb_ready_i) begin
          pend_d = pend_rem;
          if (pend_rem != '0) begin
            way_d = lowest_way(pend_rem);
          end else begin
            state_d = S_INV;
          end
        end
      end
      S_INV: begin
        if (tag_gnt_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_ACK;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RD;
          end
        end
      end
      S_ACK:   state_d = S_COOL;
      S_COOL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any walk in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      way_q   <= '0;
      pend_q  <= '0;
      tags_q  <= '0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      way_q   <= way_d;
      pend_q  <= pend_d;
      tags_q  <= tags_d;
      start_q <= start_d;
    end
  end

  // Request outputs are pure functions of registered state, so they hold
  // steady while a grant or ready is outstanding.
  assign tag_req_o   = (state_q == S_INIT) || (state_q == S_RD) || (state_q == S_INV);
  assign tag_we_o    = (state_q == S_INIT) || (state_q == S_INV);
  assign tag_idx_o   = idx_q;
  assign wb_valid_o  = (state_q == S_WB);
  assign wb_way_o    = way_q;
  assign wb_addr_o   = {tags_q[way_q*TAG_W +: TAG_W], idx_q, {OFFSET_W{1'b0}}};
  assign flush_ack_o = (state_q == S_ACK);
  // Qualified with rst_ni so that every output reads 0 while reset is held.
  assign gate_core_o = rst_ni & (stall_i || (state_q != S_IDLE));
  assign busy_o      = rst_ni & ((state_q != S_IDLE) || miss_busy_i || wb_valid_o);

endmodule
`default_nettype wire
